// File: rtl/instruction_decode_pkg.sv
// Shared definitions for the decode stage: widths, RV32I base opcodes, immediate kinds
// and the layout of the ID/EX pipeline register.
package instruction_decode_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned NREGS   = 32;
   localparam int unsigned RADDR_W = 5;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ} imm_type_e;

   typedef struct packed {
      logic [XLEN-1:0]    a;
      logic [XLEN-1:0]    b;
      logic [XLEN-1:0]    imm;
      logic [31:0]        npc;
      logic [31:0]        ir;
      logic [RADDR_W-1:0] rd;
      logic               regwr;
      logic               illegal;
      logic               valid;
   } id_ex_t;

   // R-type and unknown opcodes carry no immediate.
   function automatic imm_type_e imm_type_of(logic [6:0] opcode);
      case (opcode)
         OP_IMM, OP_LOAD, OP_JALR: return ImmI;
         OP_STORE:                 return ImmS;
         OP_BRANCH:                return ImmB;
         OP_LUI, OP_AUIPC:         return ImmU;
         OP_JAL:                   return ImmJ;
         default:                  return ImmNone;
      endcase
   endfunction

endpackage

// File: rtl/instruction_decode_if.sv
// IF/ID, write-back and ID/EX signal bundle around the decode stage.
interface instruction_decode_if;
   import instruction_decode_pkg::*;

   logic [31:0]        IF_ID_IR;
   logic [31:0]        IF_ID_NPC;
   logic               IF_ID_VALID;
   logic               STALL;
   logic               FLUSH;
   logic               WB_EN;
   logic [RADDR_W-1:0] WB_RD;
   logic [XLEN-1:0]    WB_DATA;

   logic [XLEN-1:0]    ID_EX_A;
   logic [XLEN-1:0]    ID_EX_B;
   logic [XLEN-1:0]    ID_EX_IMM;
   logic [31:0]        ID_EX_NPC;
   logic [31:0]        ID_EX_IR;
   logic [RADDR_W-1:0] ID_EX_RD;
   logic               ID_EX_REGWR;
   logic               ID_EX_ILLEGAL;
   logic               ID_EX_VALID;

   modport master (
      output IF_ID_IR, IF_ID_NPC, IF_ID_VALID, STALL, FLUSH, WB_EN, WB_RD, WB_DATA,
      input  ID_EX_A, ID_EX_B, ID_EX_IMM, ID_EX_NPC, ID_EX_IR, ID_EX_RD, ID_EX_REGWR,
             ID_EX_ILLEGAL, ID_EX_VALID
   );

   modport slave (
      input  IF_ID_IR, IF_ID_NPC, IF_ID_VALID, STALL, FLUSH, WB_EN, WB_RD, WB_DATA,
      output ID_EX_A, ID_EX_B, ID_EX_IMM, ID_EX_NPC, ID_EX_IR, ID_EX_RD, ID_EX_REGWR,
             ID_EX_ILLEGAL, ID_EX_VALID
   );

endinterface

// File: rtl/instruction_decode_reg_file.sv
// Architectural register file: two combinational reads with write-first bypass,
// one synchronous write, x0 hard-wired to zero.
module instruction_decode_reg_file
   import instruction_decode_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [RADDR_W-1:0] waddr,
   input  logic [XLEN-1:0]    wdata,
   input  logic [RADDR_W-1:0] raddr_a,
   input  logic [RADDR_W-1:0] raddr_b,
   output logic [XLEN-1:0]    rdata_a,
   output logic [XLEN-1:0]    rdata_b
);

   logic [XLEN-1:0] regs [NREGS];
   logic            wr_act;

   assign wr_act = we && (waddr != '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_act) begin
         regs[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_a = '0;
      if (raddr_a != '0) begin
         rdata_a = (wr_act && waddr == raddr_a) ? wdata : regs[raddr_a];
      end
   end

   always_comb begin
      rdata_b = '0;
      if (raddr_b != '0) begin
         rdata_b = (wr_act && waddr == raddr_b) ? wdata : regs[raddr_b];
      end
   end

endmodule

// File: rtl/instruction_decode.sv
// RV32I decode stage: register read, immediate generation and control decode,
// captured into the ID/EX pipeline register.
module instruction_decode
   import instruction_decode_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   instruction_decode_if.slave id
);

   logic [6:0]         opcode;
   logic [RADDR_W-1:0] rd;
   logic [RADDR_W-1:0] rs1;
   logic [RADDR_W-1:0] rs2;
   logic [XLEN-1:0]    rs1_data;
   logic [XLEN-1:0]    rs2_data;
   logic [XLEN-1:0]    imm;
   imm_type_e          imm_type;
   logic               legal;
   logic               has_rd;
   id_ex_t             decoded;
   id_ex_t             id_ex_d;
   id_ex_t             id_ex_q;

   assign opcode   = id.IF_ID_IR[6:0];
   assign rd       = id.IF_ID_IR[11:7];
   assign rs1      = id.IF_ID_IR[19:15];
   assign rs2      = id.IF_ID_IR[24:20];
   assign imm_type = imm_type_of(opcode);

   instruction_decode_reg_file u_reg_file (
      .clk     (clk),
      .rst     (rst),
      .we      (id.WB_EN),
      .waddr   (id.WB_RD),
      .wdata   (id.WB_DATA),
      .raddr_a (rs1),
      .raddr_b (rs2),
      .rdata_a (rs1_data),
      .rdata_b (rs2_data)
   );

   always_comb begin
      imm = '0;
      unique case (imm_type)
         ImmI:    imm = {{20{id.IF_ID_IR[31]}}, id.IF_ID_IR[31:20]};
         ImmS:    imm = {{20{id.IF_ID_IR[31]}}, id.IF_ID_IR[31:25], id.IF_ID_IR[11:7]};
         ImmB:    imm = {{19{id.IF_ID_IR[31]}}, id.IF_ID_IR[31], id.IF_ID_IR[7],
                         id.IF_ID_IR[30:25], id.IF_ID_IR[11:8], 1'b0};
         ImmU:    imm = {id.IF_ID_IR[31:12], 12'b0};
         ImmJ:    imm = {{11{id.IF_ID_IR[31]}}, id.IF_ID_IR[31], id.IF_ID_IR[19:12],
                         id.IF_ID_IR[20], id.IF_ID_IR[30:21], 1'b0};
         ImmNone: imm = '0;
         default: imm = '0;
      endcase
   end

   always_comb begin
      legal  = 1'b0;
      has_rd = 1'b0;
      case (opcode)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_REG: begin
            legal  = 1'b1;
            has_rd = 1'b1;
         end
         OP_BRANCH, OP_STORE: legal = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      decoded         = '0;
      decoded.a       = rs1_data;
      decoded.b       = rs2_data;
      decoded.imm     = imm;
      decoded.npc     = id.IF_ID_NPC;
      decoded.ir      = id.IF_ID_IR;
      decoded.rd      = has_rd ? rd : '0;
      decoded.regwr   = has_rd && (rd != '0);
      decoded.illegal = !legal;
      decoded.valid   = 1'b1;
   end

   // A bubble is an all-zero entry; stall only holds when no flush is pending.
   always_comb begin
      id_ex_d = decoded;
      if (id.FLUSH) begin
         id_ex_d = '0;
      end else if (id.STALL) begin
         id_ex_d = id_ex_q;
      end else if (!id.IF_ID_VALID) begin
         id_ex_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         id_ex_q <= '0;
      end else begin
         id_ex_q <= id_ex_d;
      end
   end

   assign id.ID_EX_A       = id_ex_q.a;
   assign id.ID_EX_B       = id_ex_q.b;
   assign id.ID_EX_IMM     = id_ex_q.imm;
   assign id.ID_EX_NPC     = id_ex_q.npc;
   assign id.ID_EX_IR      = id_ex_q.ir;
   assign id.ID_EX_RD      = id_ex_q.rd;
   assign id.ID_EX_REGWR   = id_ex_q.regwr;
   assign id.ID_EX_ILLEGAL = id_ex_q.illegal;
   assign id.ID_EX_VALID   = id_ex_q.valid;

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed scenarios plus randomized traffic against a
// behavioural model of the decode stage and register file.
module tb_instruction_decode;

   logic clk;
   logic rst;

   instruction_decode_if dif ();

   instruction_decode dut (
      .clk (clk),
      .rst (rst),
      .id  (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp;
   int n_fail;

   // Model state: architectural registers and expected ID/EX contents.
   logic [31:0] m_regs [32];
   logic [31:0] e_a, e_b, e_imm, e_npc, e_ir;
   logic [4:0]  e_rd;
   logic        e_regwr, e_ill, e_valid;

   logic [6:0] ops [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                           7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};

   function automatic logic [167:0] dut_vec();
      return {dif.ID_EX_A, dif.ID_EX_B, dif.ID_EX_IMM, dif.ID_EX_NPC, dif.ID_EX_IR,
              dif.ID_EX_RD, dif.ID_EX_REGWR, dif.ID_EX_ILLEGAL, dif.ID_EX_VALID};
   endfunction

   function automatic logic [167:0] exp_vec();
      return {e_a, e_b, e_imm, e_npc, e_ir, e_rd, e_regwr, e_ill, e_valid};
   endfunction

   function automatic logic [31:0] m_read(logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (dif.WB_EN && dif.WB_RD == r) return dif.WB_DATA;
      return m_regs[r];
   endfunction

   task automatic m_bubble();
      {e_a, e_b, e_imm, e_npc, e_ir, e_rd, e_regwr, e_ill, e_valid} = '0;
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic m_edge();
      logic [31:0] ir;
      byte         kind;
      if (!rst) begin
         m_bubble();
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         return;
      end
      ir = dif.IF_ID_IR;
      case (ir[6:0])
         7'b0110011:                         kind = "R";
         7'b0010011, 7'b0000011, 7'b1100111: kind = "I";
         7'b0100011:                         kind = "S";
         7'b1100011:                         kind = "B";
         7'b0110111, 7'b0010111:             kind = "U";
         7'b1101111:                         kind = "J";
         default:                            kind = "X";
      endcase
      if (dif.FLUSH || (!dif.STALL && !dif.IF_ID_VALID)) begin
         m_bubble();
      end else if (!dif.STALL) begin
         e_a     = m_read(ir[19:15]);
         e_b     = m_read(ir[24:20]);
         e_npc   = dif.IF_ID_NPC;
         e_ir    = ir;
         e_valid = 1'b1;
         e_ill   = (kind == "X");
         case (kind)
            "I": e_imm = {{20{ir[31]}}, ir[31:20]};
            "S": e_imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            "B": e_imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            "U": e_imm = {ir[31:12], 12'b0};
            "J": e_imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: e_imm = 32'd0;
         endcase
         e_rd    = (kind inside {"R", "I", "U", "J"}) ? ir[11:7] : 5'd0;
         e_regwr = (e_rd != 5'd0);
      end
      if (dif.WB_EN && dif.WB_RD != 5'd0) m_regs[dif.WB_RD] = dif.WB_DATA;
   endtask

   task automatic tick();
      m_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic [31:0] ir, logic [31:0] npc, logic valid);
      dif.IF_ID_IR    = ir;
      dif.IF_ID_NPC   = npc;
      dif.IF_ID_VALID = valid;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive($urandom(), $urandom(), 1'b1);
      dif.WB_EN = 1'b1; dif.WB_RD = 5'd7; dif.WB_DATA = $urandom();
      tick();
      tick();
      n_cmp++;
      if (dut_vec() !== 168'd0) begin
         n_fail++; $display("FAIL reset_outputs: got %h want 0", dut_vec());
      end
      rst = 1'b1;
      dif.WB_EN = 1'b0;
   endtask

   task automatic test_bypass();
      drive(32'h002081B3, 32'h1, 1'b1);
      dif.WB_EN = 1'b1; dif.WB_RD = 5'd1; dif.WB_DATA = 32'hDEADBEEF;
      tick();
      dif.WB_EN = 1'b0;
      n_cmp++;
      if ({dif.ID_EX_A, dif.ID_EX_B, dif.ID_EX_RD, dif.ID_EX_REGWR, dif.ID_EX_IMM}
          !== {32'hDEADBEEF, 32'h0, 5'd3, 1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL bypass_add: A=%h B=%h RD=%0d REGWR=%b IMM=%h want DEADBEEF 0 3 1 0",
                  dif.ID_EX_A, dif.ID_EX_B, dif.ID_EX_RD, dif.ID_EX_REGWR, dif.ID_EX_IMM);
      end
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
         n_fail++; $display("FAIL bypass_model: got %h want %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_store();
      drive(32'h0020A423, 32'h2, 1'b1);
      tick();
      n_cmp++;
      if ({dif.ID_EX_IMM, dif.ID_EX_RD, dif.ID_EX_REGWR, dif.ID_EX_VALID, dif.ID_EX_A}
          !== {32'h8, 5'd0, 1'b0, 1'b1, 32'hDEADBEEF}) begin
         n_fail++;
         $display("FAIL store_sw: IMM=%h RD=%0d REGWR=%b VALID=%b A=%h want 8 0 0 1 DEADBEEF",
                  dif.ID_EX_IMM, dif.ID_EX_RD, dif.ID_EX_REGWR, dif.ID_EX_VALID, dif.ID_EX_A);
      end
   endtask

   task automatic test_branch();
      drive(32'hFE000EE3, 32'h3, 1'b1);
      tick();
      n_cmp++;
      if ({dif.ID_EX_IMM, dif.ID_EX_A, dif.ID_EX_B, dif.ID_EX_REGWR}
          !== {32'hFFFFFFFC, 32'h0, 32'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL branch_beq: IMM=%h A=%h B=%h REGWR=%b want FFFFFFFC 0 0 0",
                  dif.ID_EX_IMM, dif.ID_EX_A, dif.ID_EX_B, dif.ID_EX_REGWR);
      end
   endtask

   task automatic test_stall();
      drive(32'h123452B7, 32'h10, 1'b1);
      tick();
      n_cmp++;
      if ({dif.ID_EX_IMM, dif.ID_EX_RD, dif.ID_EX_NPC, dif.ID_EX_REGWR}
          !== {32'h12345000, 5'd5, 32'h10, 1'b1}) begin
         n_fail++;
         $display("FAIL lui_load: IMM=%h RD=%0d NPC=%h REGWR=%b want 12345000 5 10 1",
                  dif.ID_EX_IMM, dif.ID_EX_RD, dif.ID_EX_NPC, dif.ID_EX_REGWR);
      end
      dif.STALL = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive($urandom(), $urandom(), 1'b1);
         tick();
         n_cmp++;
         if ({dif.ID_EX_IMM, dif.ID_EX_RD, dif.ID_EX_NPC, dif.ID_EX_IR}
             !== {32'h12345000, 5'd5, 32'h10, 32'h123452B7}) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: IMM=%h RD=%0d NPC=%h IR=%h want held lui", i,
                     dif.ID_EX_IMM, dif.ID_EX_RD, dif.ID_EX_NPC, dif.ID_EX_IR);
         end
      end
      dif.STALL = 1'b0;
   endtask

   task automatic test_flush();
      dif.STALL = 1'b1; dif.FLUSH = 1'b1;
      drive(32'h123452B7, 32'h20, 1'b1);
      tick();
      dif.STALL = 1'b0; dif.FLUSH = 1'b0;
      n_cmp++;
      if ({dif.ID_EX_VALID, dif.ID_EX_REGWR, dif.ID_EX_RD} !== 7'd0) begin
         n_fail++;
         $display("FAIL flush_over_stall: VALID=%b REGWR=%b RD=%0d want 0 0 0",
                  dif.ID_EX_VALID, dif.ID_EX_REGWR, dif.ID_EX_RD);
      end
      // add x1,x0,x0 while writing x0: neither the bypass nor the array may expose it.
      drive(32'h000000B3, 32'h21, 1'b1);
      dif.WB_EN = 1'b1; dif.WB_RD = 5'd0; dif.WB_DATA = 32'h55;
      tick();
      dif.WB_EN = 1'b0;
      n_cmp++;
      if ({dif.ID_EX_A, dif.ID_EX_B} !== 64'd0) begin
         n_fail++; $display("FAIL x0_bypass: A=%h B=%h want 0 0", dif.ID_EX_A, dif.ID_EX_B);
      end
      tick();
      n_cmp++;
      if ({dif.ID_EX_A, dif.ID_EX_B} !== 64'd0) begin
         n_fail++; $display("FAIL x0_read: A=%h B=%h want 0 0", dif.ID_EX_A, dif.ID_EX_B);
      end
   endtask

   task automatic test_illegal();
      drive(32'hFFFFFFFF, 32'h30, 1'b1);
      tick();
      n_cmp++;
      if ({dif.ID_EX_ILLEGAL, dif.ID_EX_REGWR, dif.ID_EX_VALID, dif.ID_EX_IMM}
          !== {1'b1, 1'b0, 1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL illegal_op: ILLEGAL=%b REGWR=%b VALID=%b IMM=%h want 1 0 1 0",
                  dif.ID_EX_ILLEGAL, dif.ID_EX_REGWR, dif.ID_EX_VALID, dif.ID_EX_IMM);
      end
   endtask

   task automatic test_reset_in_stall();
      drive(32'h123452B7, 32'h40, 1'b1);
      tick();
      rst = 1'b0; dif.STALL = 1'b1;
      tick();
      n_cmp++;
      if (dut_vec() !== 168'd0) begin
         n_fail++; $display("FAIL reset_in_stall: got %h want 0", dut_vec());
      end
      rst = 1'b1; dif.STALL = 1'b0;
      drive(32'h002081B3, 32'h41, 1'b1);
      tick();
      n_cmp++;
      if (dif.ID_EX_A !== 32'h0 || dif.ID_EX_VALID !== 1'b1) begin
         n_fail++;
         $display("FAIL regs_cleared: A=%h VALID=%b want 0 1", dif.ID_EX_A, dif.ID_EX_VALID);
      end
   endtask

   task automatic test_random();
      logic [31:0] ir;
      int          idx;
      for (int n = 0; n < 600; n++) begin
         ir  = $urandom();
         idx = $urandom_range(0, 9);
         if (idx < 9) ir[6:0] = ops[idx];
         drive(ir, $urandom(), $urandom_range(0, 5) != 0);
         rst       = ($urandom_range(0, 59) != 0);
         dif.STALL = ($urandom_range(0, 4) == 0);
         dif.FLUSH = ($urandom_range(0, 9) == 0);
         dif.WB_EN = $urandom_range(0, 1);
         dif.WB_RD = $urandom_range(0, 31);
         if ($urandom_range(0, 3) == 0) dif.WB_RD = ir[19:15];
         dif.WB_DATA = $urandom();
         tick();
         n_cmp++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL random[%0d]: got %h want %h", n, dut_vec(), exp_vec());
         end
      end
      rst = 1'b1; dif.STALL = 1'b0; dif.FLUSH = 1'b0; dif.WB_EN = 1'b0;
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst    = 1'b0;
      drive(32'h0, 32'h0, 1'b0);
      dif.STALL = 1'b0; dif.FLUSH = 1'b0;
      dif.WB_EN = 1'b0; dif.WB_RD = 5'd0; dif.WB_DATA = 32'h0;
      test_reset();
      test_bypass();
      test_store();
      test_branch();
      test_stall();
      test_flush();
      test_illegal();
      test_reset_in_stall();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
